// File: rtl/reset_sequencer_pkg.sv
// Shared types for the reset sequencer: FSM states, reset-cause encoding and
// a sizing helper for the shared release counter.
package reset_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_HOLD       = 3'd0,
    ST_REL_BUS    = 3'd1,
    ST_REL_PERIPH = 3'd2,
    ST_REL_CORE   = 3'd3,
    ST_RUN        = 3'd4
  } seq_state_e;

  typedef enum logic [1:0] {
    CAUSE_EXT = 2'd0,
    CAUSE_SW  = 2'd1,
    CAUSE_NDM = 2'd2,
    CAUSE_WDT = 2'd3
  } rst_cause_e;

  function automatic int unsigned max3(int unsigned a, int unsigned b, int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/rst_wdt.sv
// Watchdog for the reset sequencer: counts RUN cycles while enabled and
// flags a timeout in the cycle the count reaches WDT_CYCLES-1 unless kicked.
module rst_wdt #(
  parameter int unsigned WDT_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic wdt_en,
  input  logic wdt_kick,
  output logic timeout
);

  localparam int unsigned WDT_W = $clog2(WDT_CYCLES) + 1;
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);

  logic [WDT_W-1:0] wdt_cnt;

  // Saturating count; any kick, disable or exit from RUN clears it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wdt_cnt <= '0;
    end else if (!run || !wdt_en || wdt_kick) begin
      wdt_cnt <= '0;
    end else if (wdt_cnt != WDT_LAST) begin
      wdt_cnt <= wdt_cnt + WDT_W'(1);
    end
  end

  assign timeout = run && wdt_en && !wdt_kick && (wdt_cnt == WDT_LAST);

endmodule

// File: rtl/reset_sequencer.sv
// Ordered reset release for the SoC: bus, then peripherals, then core, with
// soft, debug (ndmreset) and watchdog re-entry and a recorded reset cause.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned PERIPH_DLY  = 8,
  parameter int unsigned CORE_DLY    = 8,
  parameter int unsigned WDT_CYCLES  = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sw_rst_req,
  input  logic       ndmreset,
  input  logic       wdt_en,
  input  logic       wdt_kick,
  output logic       bus_rst_n,
  output logic       periph_rst_n,
  output logic       core_rst_n,
  output logic [1:0] rst_cause,
  output logic       seq_busy
);

  localparam int unsigned CNT_W = $clog2(max3(HOLD_CYCLES, PERIPH_DLY, CORE_DLY)) + 1;
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] PERIPH_LD = CNT_W'(PERIPH_DLY);
  localparam logic [CNT_W-1:0] CORE_LD   = CNT_W'(CORE_DLY);

  seq_state_e       state;
  rst_cause_e       cause_q;
  logic [CNT_W-1:0] cnt;
  logic             wdt_timeout;

  rst_wdt #(
    .WDT_CYCLES(WDT_CYCLES)
  ) u_wdt (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (state == ST_RUN),
    .wdt_en  (wdt_en),
    .wdt_kick(wdt_kick),
    .timeout (wdt_timeout)
  );

  assign rst_cause = cause_q;

  // Sequencer FSM; a count of 1 means this edge completes the current wait.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_HOLD;
      cnt          <= HOLD_LD;
      bus_rst_n    <= 1'b0;
      periph_rst_n <= 1'b0;
      core_rst_n   <= 1'b0;
      cause_q      <= CAUSE_EXT;
      seq_busy     <= 1'b1;
    end else if (state == ST_RUN && (wdt_timeout || ndmreset || sw_rst_req)) begin
      state        <= ST_HOLD;
      cnt          <= HOLD_LD;
      bus_rst_n    <= 1'b0;
      periph_rst_n <= 1'b0;
      core_rst_n   <= 1'b0;
      seq_busy     <= 1'b1;
      cause_q      <= wdt_timeout ? CAUSE_WDT : (ndmreset ? CAUSE_NDM : CAUSE_SW);
    end else if (ndmreset) begin
      // Debug reset pins the sequence in HOLD until it drops.
      state        <= ST_HOLD;
      cnt          <= HOLD_LD;
      bus_rst_n    <= 1'b0;
      periph_rst_n <= 1'b0;
      core_rst_n   <= 1'b0;
      seq_busy     <= 1'b1;
      if (state != ST_HOLD) cause_q <= CAUSE_NDM;
    end else begin
      case (state)
        ST_HOLD: begin
          if (cnt <= CNT_W'(1)) begin
            state     <= ST_REL_BUS;
            bus_rst_n <= 1'b1;
            cnt       <= PERIPH_LD;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_REL_BUS: begin
          if (cnt <= CNT_W'(1)) begin
            state        <= ST_REL_PERIPH;
            periph_rst_n <= 1'b1;
            cnt          <= CORE_LD;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_REL_PERIPH: begin
          if (cnt <= CNT_W'(1)) begin
            state      <= ST_RUN;
            core_rst_n <= 1'b1;
            seq_busy   <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_RUN: begin
          state <= ST_RUN;
        end
        default: begin
          // ST_REL_CORE and illegal encodings are never entered; recover via HOLD.
          state        <= ST_HOLD;
          cnt          <= HOLD_LD;
          bus_rst_n    <= 1'b0;
          periph_rst_n <= 1'b0;
          core_rst_n   <= 1'b0;
          seq_busy     <= 1'b1;
        end
      endcase
    end
  end

endmodule
